plot_reader: RTL and testbench

Capture-and-readback end of the VGA plot interface. Sits on the same `vga_x`/`vga_y`/`vga_colour`/`vga_plot` bus that drawing engines (circle, Reuleaux) drive into the VGA adapter, and records every plot into a private 160×120 shadow framebuffer. On command it clears the shadow, or streams it back in raster order over a valid/ready port. Used for on-chip self-check and for pixel-exact comparison in benches without reaching into adapter internals.

---
 rtl/plot_pkg.sv | 26 ++
 rtl/plot_reader_if.sv | 27 ++
 rtl/fb_ram.sv | 33 +++
 rtl/plot_reader.sv | 178 +++++++++++++++++
 tb/tb_plot_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_pkg.sv
// Shared types and helpers for the VGA plot capture / readback block.
package plot_pkg;

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_DEPTH = FB_W * FB_H;
   localparam int ADDR_W   = 15;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SCAN_FETCH,
      SCAN_HOLD
   } plot_state_t;

   // y*160 + x without a multiplier: 160 = 128 + 32
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/plot_reader_if.sv
// VGA plot bus (captured) and raster readout stream (valid/ready) of plot_reader.
interface plot_reader_if #(
   parameter int COLOUR_W = 3
);

   logic [7:0]          vga_x;
   logic [6:0]          vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                vga_plot;

   logic [7:0]          out_x;
   logic [6:0]          out_y;
   logic [COLOUR_W-1:0] out_colour;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output vga_x, vga_y, vga_colour, vga_plot, out_ready,
      input  out_x, out_y, out_colour, out_valid
   );

   modport slave (
      input  vga_x, vga_y, vga_colour, vga_plot, out_ready,
      output out_x, out_y, out_colour, out_valid
   );

endinterface

// File: rtl/fb_ram.sv
// Simple dual-port shadow framebuffer: one write port, one registered read port.
// A same-address read and write returns the old word; the write still lands.
module fb_ram
   import plot_pkg::*;
#(
   parameter int DEPTH  = FB_DEPTH,
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Kept as a bare memory template so block RAM is inferred; no reset on contents or read data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/plot_reader.sv
// Records every plot on the VGA bus into a private framebuffer; on command clears it
// or streams it back in raster order, one beat per two cycles at best.
module plot_reader
   import plot_pkg::*;
#(
   parameter int WIDTH    = FB_W,
   parameter int HEIGHT   = FB_H,
   parameter int COLOUR_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   plot_reader_if.slave     bus,
   input  logic             clear_start,
   input  logic             scan_start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] plot_count,
   output logic [CNT_W-1:0] oob_count
);

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);
   localparam logic [7:0]        X_LAST   = 8'(WIDTH - 1);
   localparam logic [6:0]        Y_LAST   = 7'(HEIGHT - 1);
   localparam logic [7:0]        X_LIMIT  = 8'(WIDTH);
   localparam logic [6:0]        Y_LIMIT  = 7'(HEIGHT);

   plot_state_t       state_q,      state_d;
   logic [ADDR_W-1:0] clr_addr_q,   clr_addr_d;
   logic [7:0]        scan_x_q,     scan_x_d;
   logic [6:0]        scan_y_q,     scan_y_d;
   logic [7:0]        out_x_q,      out_x_d;
   logic [6:0]        out_y_q,      out_y_d;
   logic              done_q,       done_d;
   logic [CNT_W-1:0]  plot_count_q, plot_count_d;
   logic [CNT_W-1:0]  oob_count_q,  oob_count_d;

   logic                ram_wr_en;
   logic [ADDR_W-1:0]   ram_wr_addr;
   logic [COLOUR_W-1:0] ram_wr_data;
   logic                ram_rd_en;
   logic [ADDR_W-1:0]   ram_rd_addr;
   logic [COLOUR_W-1:0] ram_rd_data;
   logic                capture;
   logic                plot_in_range;

   assign plot_in_range = (bus.vga_x < X_LIMIT) && (bus.vga_y < Y_LIMIT);
   assign ram_rd_addr   = fb_addr(scan_x_q, scan_y_q);

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      scan_x_d     = scan_x_q;
      scan_y_d     = scan_y_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      done_d       = 1'b0;
      plot_count_d = plot_count_q;
      oob_count_d  = oob_count_q;
      ram_wr_en    = 1'b0;
      ram_wr_addr  = fb_addr(bus.vga_x, bus.vga_y);
      ram_wr_data  = bus.vga_colour;
      ram_rd_en    = 1'b0;
      capture      = 1'b0;

      case (state_q)
         IDLE: begin
            capture = 1'b1;
            if (clear_start) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end else if (scan_start) begin
               state_d  = SCAN_FETCH;
               scan_x_d = '0;
               scan_y_d = '0;
            end
         end

         // The write port belongs to the clear sweep; plots arriving now are dropped uncounted.
         CLEAR: begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_addr_q;
            ram_wr_data = '0;
            if (clr_addr_q == CLR_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               clr_addr_d = clr_addr_q + 15'd1;
            end
         end

         SCAN_FETCH: begin
            capture   = 1'b1;
            ram_rd_en = 1'b1;
            out_x_d   = scan_x_q;
            out_y_d   = scan_y_q;
            state_d   = SCAN_HOLD;
         end

         // Read data register is only reloaded in SCAN_FETCH, so a stalled beat holds steady.
         SCAN_HOLD: begin
            capture = 1'b1;
            if (bus.out_ready) begin
               state_d = SCAN_FETCH;
               if (scan_x_q == X_LAST) begin
                  scan_x_d = '0;
                  if (scan_y_q == Y_LAST) begin
                     scan_y_d = '0;
                     state_d  = IDLE;
                     done_d   = 1'b1;
                  end else begin
                     scan_y_d = scan_y_q + 7'd1;
                  end
               end else begin
                  scan_x_d = scan_x_q + 8'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (capture && bus.vga_plot) begin
         if (plot_in_range) begin
            ram_wr_en    = 1'b1;
            plot_count_d = sat_inc(plot_count_q);
         end else begin
            oob_count_d  = sat_inc(oob_count_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         clr_addr_q   <= '0;
         scan_x_q     <= '0;
         scan_y_q     <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         done_q       <= 1'b0;
         plot_count_q <= '0;
         oob_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         scan_x_q     <= scan_x_d;
         scan_y_q     <= scan_y_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         done_q       <= done_d;
         plot_count_q <= plot_count_d;
         oob_count_q  <= oob_count_d;
      end
   end

   fb_ram #(
      .DEPTH  (FB_DEPTH),
      .DATA_W (COLOUR_W)
   ) u_fb_ram (
      .clk     (clk),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data)
   );

   assign bus.out_valid  = (state_q == SCAN_HOLD);
   assign bus.out_x      = out_x_q;
   assign bus.out_y      = out_y_q;
   assign bus.out_colour = bus.out_valid ? ram_rd_data : '0;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign plot_count     = plot_count_q;
   assign oob_count      = oob_count_q;

endmodule

// File: tb/tb_plot_reader.sv
// Bench for plot_reader: table of plot vectors, clear/scan sequences, and a raster
// scoreboard fed from a bench-side framebuffer model.
module tb_plot_reader;

   localparam int CW = 3;

   typedef struct {
      logic [7:0]    x;
      logic [6:0]    y;
      logic [CW-1:0] c;
   } beat_t;

   typedef struct {
      int x;
      int y;
      int c;
      int exp_plot;
      int exp_oob;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_start;
   logic        scan_start;
   logic        busy;
   logic        done;
   logic [15:0] plot_count;
   logic [15:0] oob_count;

   plot_reader_if #(.COLOUR_W(CW)) bus ();

   plot_reader #(
      .WIDTH    (160),
      .HEIGHT   (120),
      .COLOUR_W (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .clear_start (clear_start),
      .scan_start  (scan_start),
      .busy        (busy),
      .done        (done),
      .plot_count  (plot_count),
      .oob_count   (oob_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [CW-1:0] fb_m [160*120];
   int exp_plots = 0;
   int exp_oob   = 0;
   beat_t exp_q[$];

   // Monitor state: written only by the monitor, read as deltas by the test.
   bit    mon_en = 1'b0;
   int    mon_beats = 0;
   int    mon_bad = 0;
   int    mon_gap2 = 0;
   int    mon_last_x = -1;
   int    mon_last_y = -1;
   longint mon_cyc = 0;
   longint mon_last_cyc = 0;
   string mon_bad_msg = "";

   always @(negedge clk) begin
      mon_cyc++;
      if (mon_en && bus.out_valid && bus.out_ready) begin
         beat_t e;
         if (exp_q.size() == 0) begin
            mon_bad++;
            mon_bad_msg = $sformatf("unexpected beat (%0d,%0d)", bus.out_x, bus.out_y);
         end else begin
            e = exp_q.pop_front();
            if ({bus.out_x, bus.out_y, bus.out_colour} !== {e.x, e.y, e.c}) begin
               mon_bad++;
               mon_bad_msg = $sformatf("beat got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                       bus.out_x, bus.out_y, bus.out_colour, e.x, e.y, e.c);
            end
         end
         if (mon_beats > 0 && (mon_cyc - mon_last_cyc) == 2) mon_gap2++;
         mon_last_cyc = mon_cyc;
         mon_last_x   = int'(bus.out_x);
         mon_last_y   = int'(bus.out_y);
         mon_beats++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic plot(input int x, input int y, input int c);
      logic [7:0] px;
      logic [6:0] py;
      px = 8'(x);
      py = 7'(y);
      bus.vga_x      = px;
      bus.vga_y      = py;
      bus.vga_colour = CW'(c);
      bus.vga_plot   = 1'b1;
      if (px < 8'd160 && py < 7'd120) begin
         fb_m[int'(py) * 160 + int'(px)] = CW'(c);
         exp_plots++;
      end else begin
         exp_oob++;
      end
      tick();
      bus.vga_plot = 1'b0;
   endtask

   task automatic draw_circle(input int cx, input int cy, input int r, input int c);
      int ox;
      int oy;
      int crit;
      ox   = r;
      oy   = 0;
      crit = 1 - r;
      while (oy <= ox) begin
         plot(cx + ox, cy + oy, c);
         plot(cx + oy, cy + ox, c);
         plot(cx - ox, cy + oy, c);
         plot(cx - oy, cy + ox, c);
         plot(cx - ox, cy - oy, c);
         plot(cx - oy, cy - ox, c);
         plot(cx + ox, cy - oy, c);
         plot(cx + oy, cy - ox, c);
         oy++;
         if (crit <= 0) begin
            crit += 2 * oy + 1;
         end else begin
            ox--;
            crit += 2 * (oy - ox) + 1;
         end
      end
   endtask

   task automatic build_expect();
      beat_t b;
      exp_q.delete();
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            b.x = 8'(x);
            b.y = 7'(y);
            b.c = fb_m[y * 160 + x];
            exp_q.push_back(b);
         end
      end
   endtask

   initial begin
      vec_t vecs [6];
      int   busy_cnt;
      int   done_cnt;
      int   guard;
      int   b0;
      int   bad0;
      int   g0;
      bit   stalled;

      vecs[0] = '{x: 80,  y: 20,  c: 2, exp_plot: 1, exp_oob: 0};
      vecs[1] = '{x: 120, y: 60,  c: 2, exp_plot: 2, exp_oob: 0};
      vecs[2] = '{x: 160, y: 0,   c: 5, exp_plot: 2, exp_oob: 1};
      vecs[3] = '{x: 0,   y: 120, c: 5, exp_plot: 2, exp_oob: 2};
      vecs[4] = '{x: 3,   y: 0,   c: 6, exp_plot: 3, exp_oob: 2};
      vecs[5] = '{x: 255, y: 127, c: 1, exp_plot: 3, exp_oob: 3};

      rst_n          = 1'b0;
      clear_start    = 1'b0;
      scan_start     = 1'b0;
      bus.vga_x      = '0;
      bus.vga_y      = '0;
      bus.vga_colour = '0;
      bus.vga_plot   = 1'b0;
      bus.out_ready  = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_plot_count", plot_count, 0);
      check("rst_oob_count", oob_count, 0);
      check("rst_out_x", bus.out_x, 0);
      check("rst_out_y", bus.out_y, 0);
      check("rst_out_colour", bus.out_colour, 0);

      // Clear sweep: busy for exactly 19200 cycles, then a single done in IDLE.
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check("clear_busy_next_cycle", busy, 1);
      busy_cnt = 0;
      guard    = 0;
      while (!done && guard < 25000) begin
         if (busy) busy_cnt++;
         tick();
         guard++;
      end
      check("clear_done_seen", done, 1);
      check("clear_busy_cycles", busy_cnt, 19200);
      check("clear_busy_at_done", busy, 0);
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("clear_done_extra", done_cnt, 0);
      for (int i = 0; i < 160 * 120; i++) fb_m[i] = '0;

      for (int i = 0; i < 6; i++) begin
         plot(vecs[i].x, vecs[i].y, vecs[i].c);
         check($sformatf("vec%0d_plot_count", i), plot_count, vecs[i].exp_plot);
         check($sformatf("vec%0d_oob_count", i), oob_count, vecs[i].exp_oob);
      end

      draw_circle(80, 60, 40, 2);
      check("circle_plot_count", plot_count, exp_plots);
      check("circle_oob_count", oob_count, exp_oob);

      // Full scan: latency, stall at (3,0), scoreboard over every pixel.
      b0   = mon_beats;
      bad0 = mon_bad;
      g0   = mon_gap2;
      build_expect();
      mon_en     = 1'b1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      check("scan_fetch_valid_low", bus.out_valid, 0);
      check("scan_busy", busy, 1);
      tick();
      check("scan_first_valid", bus.out_valid, 1);
      check("scan_first_x", bus.out_x, 0);
      check("scan_first_y", bus.out_y, 0);
      stalled = 1'b0;
      guard   = 0;
      while (!done && guard < 50000) begin
         if (!stalled && bus.out_valid && bus.out_x == 8'd3 && bus.out_y == 7'd0) begin
            stalled       = 1'b1;
            bus.out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               tick();
               check($sformatf("stall%0d_valid", i), bus.out_valid, 1);
               check($sformatf("stall%0d_x", i), bus.out_x, 3);
               check($sformatf("stall%0d_y", i), bus.out_y, 0);
               check($sformatf("stall%0d_colour", i), bus.out_colour, int'(fb_m[3]));
            end
            bus.out_ready = 1'b1;
            tick();
            check("after_stall_gap", bus.out_valid, 0);
            tick();
            check("after_stall_valid", bus.out_valid, 1);
            check("after_stall_x", bus.out_x, 4);
            check("after_stall_y", bus.out_y, 0);
         end
         tick();
         guard++;
      end
      check("scan_done_seen", done, 1);
      check("scan_busy_at_done", busy, 0);
      check("scan_stall_hit", stalled, 1);
      check("scan_beats", mon_beats - b0, 19200);
      check("scan_bad_beats", mon_bad - bad0, 0);
      if (mon_bad != bad0) $display("last bad: %s", mon_bad_msg);
      check("scan_queue_left", exp_q.size(), 0);
      check("scan_last_x", mon_last_x, 159);
      check("scan_last_y", mon_last_y, 119);
      check("scan_gap2_beats", mon_gap2 - g0, 19198);
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) done_cnt++;
      end
      check("scan_done_extra", done_cnt, 0);
      mon_en = 1'b0;

      // Reset at beat 100 of a scan aborts it; shadow contents survive.
      b0   = mon_beats;
      bad0 = mon_bad;
      build_expect();
      mon_en     = 1'b1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      guard = 0;
      while ((mon_beats - b0) < 100 && guard < 1000) begin
         tick();
         guard++;
      end
      mon_en = 1'b0;
      check("abort_beats_reached", mon_beats - b0, 100);
      check("abort_bad_beats", mon_bad - bad0, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_plot_count", plot_count, 0);
      check("abort_oob_count", oob_count, 0);
      exp_q.delete();
      tick();

      // Rescan without clearing: first 24 rows include the circle top and (80,20).
      b0   = mon_beats;
      bad0 = mon_bad;
      build_expect();
      mon_en     = 1'b1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      guard = 0;
      while ((mon_beats - b0) < 3840 && guard < 20000) begin
         tick();
         guard++;
      end
      mon_en = 1'b0;
      check("rescan_beats_reached", int'((mon_beats - b0) >= 3840), 1);
      check("rescan_bad_beats", mon_bad - bad0, 0);
      if (mon_bad != bad0) $display("last bad: %s", mon_bad_msg);
      check("rescan_busy", busy, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
